// File: rtl/uart_tx_one_module.sv
// UART transmitter: serialises one byte as start(0), 8 data bits LSB first, stop(1).
// Each bit is held for CLKS_PER_BIT clocks. busy/done mirror the matching receiver.
module uart_tx_one_module #(
  parameter int CLKS_PER_BIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_data_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          bit_end;

  // With CLKS_PER_BIT=1 the counter stays at 0 and every cycle ends a bit.
  assign bit_end = (clk_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
    end else if (soft_rst) begin
      state       <= IDLE;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_data_out <= 1'b1;
          tx_busy     <= 1'b0;
          if (tx_start) begin
            shift_reg   <= tx_data_in;
            state       <= START;
            tx_data_out <= 1'b0;
            tx_busy     <= 1'b1;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            state       <= DATA;
            tx_data_out <= shift_reg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state       <= STOP;
              tx_data_out <= 1'b1;
            end else begin
              // Drive the next bit straight from the pre-shift register.
              shift_reg   <= shift_reg >> 1;
              bit_cnt     <= bit_cnt + 3'd1;
              tx_data_out <= shift_reg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          tx_data_out <= 1'b1;
          tx_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_one_module.sv
// Bench for uart_tx_one_module: frame-level reference model, CLKS_PER_BIT=3 and =1 instances.
module tb_uart_tx_one_module;

  localparam int CPB = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       out3, busy3, done3;
  logic       out1, busy1, done1;
  bit         sel1 = 1'b0;
  logic       o_out, o_busy, o_done;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  uart_tx_one_module #(.CLKS_PER_BIT(CPB)) u_dut3 (
    .clk(clk), .rst(rst_n), .soft_rst(soft_rst), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_data_out(out3), .tx_busy(busy3), .tx_done(done3)
  );

  uart_tx_one_module #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .soft_rst(soft_rst), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_data_out(out1), .tx_busy(busy1), .tx_done(done1)
  );

  assign o_out  = sel1 ? out1  : out3;
  assign o_busy = sel1 ? busy1 : busy3;
  assign o_done = sel1 ? done1 : done3;

  always #5 clk = ~clk;

  always @(posedge clk) if (o_done === 1'b1) done_cnt++;

  // Frame bit k of a byte: 0 is start, 1..8 data LSB first, 9 is stop.
  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return d[k-1];
  endfunction

  function automatic int cpb_now();
    return sel1 ? 1 : CPB;
  endfunction

  task automatic start_frame(input logic [7:0] d);
    tx_start   = 1'b1;
    tx_data_in = d;
    @(negedge clk);
    tx_start   = 1'b0;
  endtask

  // Called right after the accepting edge; returns in the tx_done cycle.
  task automatic check_frame(input logic [7:0] exp, input int chg_idx, input logic chg_start,
                             input logic [7:0] chg_data, input int rel_idx, input string name);
    int c;
    c = cpb_now();
    for (int i = 0; i < 10 * c; i++) begin
      if (i == chg_idx) begin
        tx_start   = chg_start;
        tx_data_in = chg_data;
      end
      if (i == rel_idx) tx_start = 1'b0;
      checks++;
      if (o_out !== fbit(exp, i / c) || o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: out=%b busy=%b done=%b, required out=%b busy=1 done=0",
                 name, i, o_out, o_busy, o_done, fbit(exp, i / c));
      end
      @(negedge clk);
    end
    checks++;
    if (o_out !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done-cycle: out=%b busy=%b done=%b, required out=1 busy=0 done=1",
               name, o_out, o_busy, o_done);
    end
  endtask

  task automatic check_idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (o_out !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL %s idle cycle %0d: out=%b busy=%b done=%b, required out=1 busy=0 done=0",
                 name, i, o_out, o_busy, o_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    soft_rst   = 1'b0;
    tx_start   = 1'b1;
    tx_data_in = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 12 * CPB; i++) begin
      checks++;
      if ({out3, busy3, done3, out1, busy1, done1} !== 6'b100_100) begin
        errors++;
        $display("FAIL reset cycle %0d: out/busy/done cpb3=%b%b%b cpb1=%b%b%b, required 100 100",
                 i, out3, busy3, done3, out1, busy1, done1);
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_idle(3, "post_reset");
  endtask

  task automatic test_single();
    start_frame(8'hA5);
    check_frame(8'hA5, -1, 1'b0, 8'h00, -1, "single_a5");
    @(negedge clk);
    check_idle(2, "single_after");
  endtask

  task automatic test_loopback();
    logic [7:0] rx;
    logic       s_bit, p_bit;
    int         d0, n, c;
    c = cpb_now();
    for (int b = 0; b < 256; b++) begin
      d0 = done_cnt;
      start_frame(8'(b));
      repeat (c / 2) @(negedge clk);
      s_bit = o_out;
      for (int k = 0; k < 8; k++) begin
        repeat (c) @(negedge clk);
        rx[k] = o_out;
      end
      repeat (c) @(negedge clk);
      p_bit = o_out;
      n = 0;
      while (o_busy === 1'b1 && n < 4 * c) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 4 * c) begin
        errors++;
        $display("FAIL loop_timeout byte %0d: busy still %b after %0d cycles, required 0", b, o_busy, n);
      end
      @(negedge clk);
      checks++;
      if (rx !== 8'(b)) begin
        errors++;
        $display("FAIL loop_data: received %h, required %h", rx, 8'(b));
      end
      checks++;
      if (s_bit !== 1'b0 || p_bit !== 1'b1) begin
        errors++;
        $display("FAIL loop_framing byte %0d: start=%b stop=%b, required 0 and 1", b, s_bit, p_bit);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
        errors++;
        $display("FAIL loop_done byte %0d: %0d done pulses, required 1", b, done_cnt - d0);
      end
    end
  endtask

  task automatic test_busy_protect();
    logic [7:0] d, g;
    int         idx;
    start_frame(8'h3C);
    check_frame(8'h3C, 4 * CPB + 1, 1'b1, 8'hC3, 4 * CPB + 2, "busy_3c");
    @(negedge clk);
    check_idle(12 * CPB, "busy_no_second");
    for (int r = 0; r < 6; r++) begin
      d   = 8'($urandom);
      g   = 8'($urandom);
      idx = $urandom_range(1, 10 * CPB - 2);
      start_frame(d);
      check_frame(d, idx, 1'b1, g, idx + 1, "busy_rand");
      @(negedge clk);
      check_idle(2, "busy_rand_after");
    end
  endtask

  task automatic test_back_to_back();
    tx_start   = 1'b1;
    tx_data_in = 8'h01;
    @(negedge clk);
    check_frame(8'h01, 5, 1'b1, 8'h80, -1, "b2b_first");
    @(negedge clk);
    check_frame(8'h80, -1, 1'b0, 8'h00, 2, "b2b_second");
    @(negedge clk);
    check_idle(4, "b2b_after");
  endtask

  task automatic test_soft_reset();
    int d0;
    start_frame(8'h55);
    for (int i = 0; i < 5 * CPB + 1; i++) begin
      checks++;
      if (o_out !== fbit(8'h55, i / CPB) || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL srst_pre cycle %0d: out=%b busy=%b, required out=%b busy=1",
                 i, o_out, o_busy, fbit(8'h55, i / CPB));
      end
      @(negedge clk);
    end
    d0 = done_cnt;
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    check_idle(12 * CPB, "srst_abort");
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL srst_done: %0d done pulses after abort, required 0", done_cnt - d0);
    end
    start_frame(8'h0F);
    check_frame(8'h0F, -1, 1'b0, 8'h00, -1, "srst_0f");
    @(negedge clk);
    check_idle(2, "srst_after");
  endtask

  task automatic test_cpb1();
    logic [7:0] d1, d2;
    sel1 = 1'b1;
    check_idle(2, "cpb1_idle");
    for (int r = 0; r < 12; r++) begin
      d1 = 8'($urandom);
      start_frame(d1);
      check_frame(d1, -1, 1'b0, 8'h00, -1, "cpb1_rand");
      @(negedge clk);
    end
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    tx_start   = 1'b1;
    tx_data_in = d1;
    @(negedge clk);
    check_frame(d1, 3, 1'b1, d2, -1, "cpb1_b2b_first");
    @(negedge clk);
    check_frame(d2, -1, 1'b0, 8'h00, 1, "cpb1_b2b_second");
    @(negedge clk);
    check_idle(3, "cpb1_after");
    sel1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_busy_protect();
    test_back_to_back();
    test_soft_reset();
    test_cpb1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
